// File: rtl/instr_mem_fetch.sv
// Loadable byte-addressed instruction memory for the fetch stage: program-load port in BOOT,
// registered 1-cycle valid/ready fetch with stall-hold, flush and alignment/range faults.
module instr_mem_fetch #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = 64,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    parameter bit          START_RUN   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [3:0]        load_be,
    input  logic              load_done,
    output logic              load_err,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              resp_valid,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              fault_misaligned,
    output logic              fault_range,
    output logic              state_run
);

    localparam int unsigned       IdxW     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(DEPTH_BYTES - 4);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e              state_q;
    logic [7:0]          mem_q [DEPTH_BYTES];
    logic                load_err_q;
    logic                resp_valid_q;
    logic [31:0]         instr_q;
    logic [ADDR_W-1:0]   resp_addr_q;
    logic                fault_mis_q;
    logic                fault_rng_q;

    logic                is_run;
    logic                load_ok;
    logic [IdxW-1:0]     wr_idx;
    logic                req_mis;
    logic                req_rng;
    logic [IdxW-1:0]     rd_idx;
    logic [31:0]         rd_word;
    logic                accept;

    assign is_run  = (state_q == StRun);
    assign load_ok = load_en && !is_run && (load_addr[1:0] == 2'b00) && (load_addr <= LastWord);
    assign wr_idx  = load_addr[IdxW-1:0];

    assign req_mis = (req_addr[1:0] != 2'b00);
    assign req_rng = (req_addr > LastWord);
    // Index forced to 0 when out of range so the array is never read past its end.
    assign rd_idx  = req_rng ? '0 : req_addr[IdxW-1:0];
    assign rd_word = {mem_q[rd_idx + IdxW'(3)], mem_q[rd_idx + IdxW'(2)],
                      mem_q[rd_idx + IdxW'(1)], mem_q[rd_idx]};

    assign req_ready = is_run && !(stall && resp_valid_q) && !flush;
    assign accept    = req_valid && req_ready;

    // Memory contents are deliberately not reset; a write on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && load_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (load_be[k]) mem_q[wr_idx + IdxW'(k)] <= load_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= START_RUN ? StRun : StBoot;
            load_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            instr_q      <= NOP_INSTR;
            resp_addr_q  <= '0;
            fault_mis_q  <= 1'b0;
            fault_rng_q  <= 1'b0;
        end else begin
            if (!is_run && load_done) state_q <= StRun;
            load_err_q <= load_en && !load_ok;

            if (flush) begin
                resp_valid_q <= 1'b0;
                instr_q      <= NOP_INSTR;
                fault_mis_q  <= 1'b0;
                fault_rng_q  <= 1'b0;
            end else if (stall && resp_valid_q) begin
                resp_valid_q <= resp_valid_q;
            end else if (accept) begin
                resp_valid_q <= 1'b1;
                resp_addr_q  <= req_addr;
                fault_mis_q  <= req_mis;
                fault_rng_q  <= req_rng;
                instr_q      <= (req_mis || req_rng) ? NOP_INSTR : rd_word;
            end else begin
                resp_valid_q <= 1'b0;
                instr_q      <= NOP_INSTR;
                fault_mis_q  <= 1'b0;
                fault_rng_q  <= 1'b0;
            end
        end
    end

    assign state_run        = is_run;
    assign load_err         = load_err_q;
    assign resp_valid       = resp_valid_q;
    assign Instruction      = instr_q;
    assign resp_addr        = resp_addr_q;
    assign fault_misaligned = fault_mis_q;
    assign fault_range      = fault_rng_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch: directed stimulus pushes expected responses,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_instr_mem_fetch;

    localparam int unsigned DEPTH_BYTES = 256;
    localparam int unsigned ADDR_W      = 64;
    localparam logic [31:0] NOP         = 32'h00000013;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              mis;
        logic              rng;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [31:0]       load_data = '0;
    logic [3:0]        load_be = '0;
    logic              load_done = 1'b0;
    logic              load_err;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              resp_valid;
    logic [31:0]       Instruction;
    logic [ADDR_W-1:0] resp_addr;
    logic              fault_misaligned;
    logic              fault_range;
    logic              state_run;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    instr_mem_fetch #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .ADDR_W     (ADDR_W),
        .NOP_INSTR  (NOP),
        .START_RUN  (1'b0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_be         (load_be),
        .load_done       (load_done),
        .load_err        (load_err),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .stall           (stall),
        .flush           (flush),
        .resp_valid      (resp_valid),
        .Instruction     (Instruction),
        .resp_addr       (resp_addr),
        .fault_misaligned(fault_misaligned),
        .fault_range     (fault_range),
        .state_run       (state_run)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid response must match the oldest expectation; idle cycles show NOP.
    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp_valid", 64'(resp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_instr", 64'(Instruction), 64'(e.instr));
                    check("resp_addr", resp_addr, e.addr);
                    check("resp_faults", {62'd0, fault_misaligned, fault_range},
                          {62'd0, e.mis, e.rng});
                end
            end else begin
                check("idle_instr", 64'(Instruction), 64'(NOP));
                check("idle_faults", {62'd0, fault_misaligned, fault_range}, 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit exp_err);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        load_be   = be;
        cyc();
        load_en = 1'b0;
        check("load_err", 64'(load_err), 64'(exp_err));
    endtask

    task automatic push(input logic [31:0] i, input logic [ADDR_W-1:0] a, input bit m,
                        input bit r);
        exp_t e;
        e.instr = i;
        e.addr  = a;
        e.mis   = m;
        e.rng   = r;
        sb_q.push_back(e);
    endtask

    // Issue one accepted fetch; request left asserted so fetches can run back to back.
    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] i, input bit m,
                         input bit r);
        req_valid = 1'b1;
        req_addr  = a;
        #0;
        check("req_ready_run", 64'(req_ready), 64'd1);
        push(i, a, m, r);
        cyc();
    endtask

    initial begin
        // Reset
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_state_run", 64'(state_run), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_instr", 64'(Instruction), 64'(NOP));
        check("rst_resp_addr", resp_addr, 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        mon_en = 1'b1;

        // Boot gating: requests are refused
        req_valid = 1'b1;
        req_addr  = 64'd0;
        #0;
        check("boot_req_ready", 64'(req_ready), 64'd0);
        cyc();
        req_valid = 1'b0;
        check("boot_resp_valid", 64'(resp_valid), 64'd0);

        // Program load
        load(64'd0, 32'h003100B3, 4'hF, 1'b0);
        load(64'd4, 32'h0062F233, 4'hF, 1'b0);
        load(64'd8, 32'hAABBCCDD, 4'hF, 1'b0);
        load(64'd8, 32'h11223344, 4'b0101, 1'b0);
        load(64'd252, 32'hCAFEF00D, 4'hF, 1'b0);
        load(64'd6, 32'hFFFFFFFF, 4'hF, 1'b1);
        cyc();
        check("load_err_pulse_clears", 64'(load_err), 64'd0);
        load(64'd256, 32'hFFFFFFFF, 4'hF, 1'b1);
        check("still_boot", 64'(state_run), 64'd0);

        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        check("state_run_after_done", 64'(state_run), 64'd1);

        // Back-to-back fetches, byte enables, faults
        fetch(64'd0, 32'h003100B3, 1'b0, 1'b0);
        fetch(64'd4, 32'h0062F233, 1'b0, 1'b0);
        fetch(64'd8, 32'hAA22CC44, 1'b0, 1'b0);
        fetch(64'd2, NOP, 1'b1, 1'b0);
        fetch(64'd252, 32'hCAFEF00D, 1'b0, 1'b0);
        fetch(64'd256, NOP, 1'b0, 1'b1);
        fetch(64'd258, NOP, 1'b1, 1'b1);
        req_valid = 1'b0;
        cyc();
        check("idle_resp_addr_held", resp_addr, 64'd258);

        // Load in RUN is rejected and leaves memory alone
        load(64'd0, 32'h00000000, 4'hF, 1'b1);
        fetch(64'd0, 32'h003100B3, 1'b0, 1'b0);
        req_valid = 1'b0;

        // Stall holds, flush overrides stall
        req_valid = 1'b1;
        req_addr  = 64'd4;
        stall     = 1'b1;
        #0;
        check("stall_req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            push(32'h003100B3, 64'd0, 1'b0, 1'b0);
            cyc();
            check("stall_req_ready_held", 64'(req_ready), 64'd0);
        end
        flush = 1'b1;
        #0;
        check("flush_req_ready", 64'(req_ready), 64'd0);
        cyc();
        check("flush_resp_valid", 64'(resp_valid), 64'd0);
        flush = 1'b0;
        stall = 1'b0;
        fetch(64'd4, 32'h0062F233, 1'b0, 1'b0);
        req_valid = 1'b0;
        cyc();

        // Reset during a stalled valid response
        fetch(64'd0, 32'h003100B3, 1'b0, 1'b0);
        req_valid = 1'b0;
        stall     = 1'b1;
        push(32'h003100B3, 64'd0, 1'b0, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        stall = 1'b0;
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_instr", 64'(Instruction), 64'(NOP));
        check("midrst_resp_addr", resp_addr, 64'd0);
        check("midrst_state_run", 64'(state_run), 64'd0);
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        fetch(64'd0, 32'h003100B3, 1'b0, 1'b0);
        req_valid = 1'b0;
        cyc();
        cyc();

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, loadable instruction memory for the pipelined RISC-V core's fetch stage, replacing the combinational ROM.
- Byte-addressed, little-endian, with a registered 1-cycle read.
- Valid/ready fetch request, plus stall-hold and flush for the IF/ID boundary.
- Alignment/range fault reporting.
- Word-wide program-load port active only in the BOOT state.

Parameters:
- DEPTH_BYTES, 256, memory size in bytes; multiple of 4, at least 8.
- ADDR_W, 64, width of fetch and load addresses.
- NOP_INSTR, 32'h00000013, instruction driven when no valid or faulting response (addi x0,x0,0).
- START_RUN, 0, 1 = reset enters RUN directly (preinitialised simulation image); 0 = reset enters BOOT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  byte address of the load word; must be 4-aligned.
- load_data  in  32  load word; byte k is written to mem[load_addr+k].
- load_be  in  4  per-byte write enables.
- load_done  in  1  pulse; BOOT -> RUN.
- load_err  out  1  1-cycle pulse when a load write is rejected.
- req_valid  in  1  fetch request.
- req_addr  in  ADDR_W  fetch byte address (PC).
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- stall  in  1  downstream stall; hold the current response.
- flush  in  1  discard the held response and any same-cycle request.
- resp_valid  out  1  Instruction/resp_addr/faults valid.
- Instruction  out  32  fetched instruction, little-endian.
- resp_addr  out  ADDR_W  address of the returned instruction.
- fault_misaligned  out  1  req_addr[1:0] != 0.
- fault_range  out  1  req_addr > DEPTH_BYTES-4.
- state_run  out  1  1 in RUN, 0 in BOOT.

Behaviour:

Reset:
- State = RUN if START_RUN else BOOT.
- resp_valid=0, Instruction=NOP_INSTR, resp_addr=0, faults=0, load_err=0.
- The memory array is NOT cleared; contents survive reset.

FSM:
- BOOT -> RUN on load_done.
- RUN has no exit except reset.
- load_done in RUN is ignored.

Load port:
- Writes occur only in BOOT, with load_en=1, load_addr[1:0]==0 and load_addr <= DEPTH_BYTES-4.
- Each byte k with load_be[k]=1 is written on the clock edge.
- load_en under any other condition (RUN, misaligned, out of range): no write; load_err=1 the next cycle.
- load_en and load_done in the same BOOT cycle: the write is performed, then the state moves to RUN.

Fetch:
- req_ready = state_run && !(stall && resp_valid) && !flush.
- Accepted request at edge N: at edge N+1, resp_valid=1 and resp_addr=req_addr.
  - Instruction = {mem[a+3],mem[a+2],mem[a+1],mem[a]}, where a = req_addr.
- Fault response:
  - If misaligned or out of range: Instruction=NOP_INSTR and the relevant fault flag(s)=1; both flags may be set together.
  - Memory is never indexed beyond DEPTH_BYTES-1.
- Stall: stall=1 with resp_valid=1 holds all response outputs unchanged. stall with resp_valid=0 has no effect on req_ready.
- Flush: flush=1 at an edge gives resp_valid=0, Instruction=NOP_INSTR and faults=0 next cycle.
  - Flush overrides stall and drops any same-cycle request.
- No accepted request and no stall hold: resp_valid=0, Instruction=NOP_INSTR, faults=0; resp_addr holds its last value.
- In BOOT: req_ready=0 and resp_valid stays 0.
- Reset mid-operation: the response is dropped on the same edge and outputs return to their reset values.
  - An in-flight load write on the reset edge is not performed.

Width rules:
- Address comparisons are unsigned at ADDR_W.
- Byte index = req_addr truncated to clog2(DEPTH_BYTES) bits, used only after the range check passes.

Test Plan:
- Load and fetch: in BOOT, load word 32'h003100B3 @0 and 32'h0062F233 @4 with be=4'hF, then pulse load_done. Fetch 0 then 4 back-to-back -> Instruction 003100B3 then 0062F233 on consecutive cycles, resp_addr 0, 4.
- Byte enable: load 32'hAABBCCDD @8 with be=4'hF, then 32'h11223344 with be=4'b0101 -> fetch 8 returns 32'hAA22CC44.
- Faults (DEPTH_BYTES=256): fetch 2 -> fault_misaligned=1, Instruction 00000013. Fetch 252 -> valid data, no fault. Fetch 256 -> fault_range=1. Fetch 258 -> both flags=1.
- Stall/flush: fetch 0, then hold stall=1 for 3 cycles -> outputs frozen, req_ready=0. Assert flush with stall still 1 -> resp_valid=0 next cycle. Release -> fetch 4 returns 0062F233.
- Boot gating: in BOOT, req_valid=1 -> req_ready=0, resp_valid=0. In RUN, load_en@0 -> no write, load_err pulse, fetch 0 unchanged. Misaligned load_addr=6 in BOOT -> load_err.
- Reset mid-run: reset during a stalled valid response -> next cycle resp_valid=0, Instruction 00000013, state_run=START_RUN. After load_done, fetch 0 still returns 003100B3 (memory retained).
